vedic_mul8_seq: RTL and testbench

VEDIC_MUL8_SEQ -- requirements
Module: vedic_mul8_seq

---
 rtl/vedic_mul8_seq.sv | 54 +++++
 tb/tb_vedic_mul8_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/vedic_mul8_seq.sv
// vedic_mul8_seq: sequential 8x8 unsigned multiplier built from one 2x2 digit cell over 16 cycles
module vedic_mul8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state, nxt;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc, term, sum;
  logic [3:0]  idx, pp;
  logic [1:0]  da, db;
  logic [2:0]  dsum;
  always_comb begin
    da   = a_q[{idx[1:0], 1'b0} +: 2];
    db   = b_q[{idx[3:2], 1'b0} +: 2];
    pp   = 4'(da) * 4'(db);
    dsum = 3'(idx[1:0]) + 3'(idx[3:2]);
    term = 16'(pp) << {dsum, 1'b0};
    sum  = acc + term;
    nxt  = state == IDLE ? (start ? RUN : IDLE) :
           state == RUN  ? (idx == 4'd15 ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      idx   <= '0;
      P     <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        a_q <= A;
        b_q <= B;
        acc <= '0;
        idx <= '0;
      end
      if (state == RUN) begin
        acc <= sum;
        idx <= idx + 4'd1;
        if (idx == 4'd15) P <= sum;
      end
    end
  end
endmodule

// File: tb/tb_vedic_mul8_seq.sv
// tb_vedic_mul8_seq: directed and random checks of product, latency, hold, abort and start handling
module tb_vedic_mul8_seq;
  logic        clk = 0, rst = 1, start = 0;
  logic [7:0]  A = 0, B = 0;
  logic [15:0] P;
  logic        busy, done;
  int          n_run = 0, n_fail = 0;

  vedic_mul8_seq dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .P(P), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one operation from IDLE; returns latency, busy-cycle count, busy&done overlap and whether P held its old value
  task automatic mul(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                     output int lat, output int nb, output bit ovl, output bit held);
    logic [15:0] prev;
    prev = P;
    nb = 0;
    ovl = 0;
    held = 1;
    @(negedge clk);
    A = a; B = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 1;
    while (!done && lat < 40) begin
      nb += busy;
      if (P !== prev) held = 0;
      if (scramble) begin
        A = 8'($urandom); B = 8'($urandom); start = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (busy && done) ovl = 1;
    end
    start = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, nb, dn, t1, t2;
    bit ovl, held;
    logic [7:0] corners [4];
    logic [7:0] ra, rb;
    corners = '{8'h00, 8'h01, 8'h80, 8'hFF};
    repeat (2) @(posedge clk);
    #1;
    check("reset_P", P, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 0;

    mul(8'hFF, 8'hFF, 0, lat, nb, ovl, held);
    check("ff_P", P, 32'hFE01);
    check("ff_lat", lat, 17);
    check("ff_busy_cycles", nb, 16);
    check("ff_overlap", ovl, 0);

    mul(8'hA5, 8'h3C, 0, lat, nb, ovl, held);
    check("a5_P", P, 32'h26AC);
    mul(8'h00, 8'hB7, 0, lat, nb, ovl, held);
    check("hold_prev_P", held, 1);
    check("zero_P", P, 0);

    // start held high: ops accepted at edges 0, 18, 36
    @(negedge clk);
    A = 8'h03; B = 8'h05; start = 1;
    dn = 0; t1 = -1; t2 = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        if (t1 < 0) t1 = c; else t2 = c;
        check("held_start_P", P, 32'h000F);
      end
    end
    start = 0;
    check("held_start_count", dn, 2);
    check("held_start_spacing", t2 - t1, 18);
    for (int c = 0; c < 30 && (busy || done); c++) @(posedge clk) #1;
    check("held_start_idle", busy | done, 0);
    check("held_start_lastP", P, 32'h000F);

    // abort mid-RUN at idx 8
    @(negedge clk);
    A = 8'h12; B = 8'h34; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("abort_P", P, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      dn += done;
    end
    check("abort_no_done", dn, 0);

    mul(8'h9C, 8'h47, 1, lat, nb, ovl, held);
    check("scramble_P", P, 32'h2B44);
    check("scramble_lat", lat, 17);

    foreach (corners[i]) foreach (corners[j]) begin
      mul(corners[i], corners[j], 0, lat, nb, ovl, held);
      check($sformatf("corner_%0h_%0h", corners[i], corners[j]), P, 16'(corners[i]) * 16'(corners[j]));
      check("corner_lat", lat, 17);
    end

    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      mul(ra, rb, 0, lat, nb, ovl, held);
      check($sformatf("rand_%0h_%0h", ra, rb), P, 16'(ra) * 16'(rb));
      check("rand_lat", lat, 17);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
